dcache_frontend: RTL and testbench

- Blocking, direct-mapped, one-word-per-line data cache between the pipeline's load port and the memory controller's data read port.
- Hits return the next cycle. A miss issues one read pulse to the memory controller, waits for the matching broadcast, fills the line and returns the data.
- At most one memory request is outstanding, so the controller's data queue can never overflow.

---
 rtl/dcache_frontend_if.sv | 25 ++
 rtl/dcache_frontend.sv | 156 +++++++++++++++
 tb/tb_dcache_frontend.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_frontend_if.sv
// rtl/dcache_frontend_if.sv - load port and memory read port bundle for dcache_frontend
interface dcache_frontend_if;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_addr;
  logic [15:0] resp_data;
  logic        flush;
  logic        mem_re;
  logic [15:0] mem_raddr;
  logic        mem_ready;
  logic [15:0] mem_raddr_in;
  logic [15:0] mem_rdata;

  modport master (
    output req_valid, req_addr, flush, mem_ready, mem_raddr_in, mem_rdata,
    input  req_ready, resp_valid, resp_addr, resp_data, mem_re, mem_raddr
  );

  modport slave (
    input  req_valid, req_addr, flush, mem_ready, mem_raddr_in, mem_rdata,
    output req_ready, resp_valid, resp_addr, resp_data, mem_re, mem_raddr
  );
endinterface

// File: rtl/dcache_frontend.sv
// rtl/dcache_frontend.sv - blocking direct-mapped one-word-line data cache
// Optional hit/miss counters enabled by DCACHE_STATS_EN.
module dcache_frontend #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef DCACHE_STATS_EN
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
`endif
  dcache_frontend_if.slave     bus
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [15:0]        miss_addr_q, miss_addr_d;
  logic               resp_valid_q, resp_valid_d;
  logic [15:0]        resp_addr_q, resp_addr_d;
  logic [15:0]        resp_data_q, resp_data_d;
  logic               mem_re_q, mem_re_d;
  logic [15:0]        mem_raddr_q, mem_raddr_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [TAG_W-1:0]   tag_d  [LINES];
  logic [15:0]        data_q [LINES];
  logic [15:0]        data_d [LINES];
  logic               hit_inc, miss_inc;

  logic [INDEX_BITS-1:0] req_idx, miss_idx;
  logic                  lookup_hit, fill_match;

  assign req_idx    = bus.req_addr[INDEX_BITS-1:0];
  assign miss_idx   = miss_addr_q[INDEX_BITS-1:0];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == bus.req_addr[15:INDEX_BITS]);
  assign fill_match = bus.mem_ready && (bus.mem_raddr_in == miss_addr_q);

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    resp_valid_d = 1'b0;
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    mem_re_d     = 1'b0;
    mem_raddr_d  = mem_raddr_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;

    // Flush clears first so a fill landing in the same cycle still marks its line valid.
    if (bus.flush) valid_d = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (lookup_hit && !bus.flush) begin
            resp_valid_d = 1'b1;
            resp_addr_d  = bus.req_addr;
            resp_data_d  = data_q[req_idx];
            hit_inc      = 1'b1;
          end else begin
            miss_addr_d = bus.req_addr;
            mem_re_d    = 1'b1;
            mem_raddr_d = bus.req_addr;
            state_d     = S_ISSUE;
            miss_inc    = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (fill_match) begin
          valid_d[miss_idx] = 1'b1;
          tag_d[miss_idx]   = miss_addr_q[15:INDEX_BITS];
          data_d[miss_idx]  = bus.mem_rdata;
          resp_valid_d      = 1'b1;
          resp_addr_d       = miss_addr_q;
          resp_data_d       = bus.mem_rdata;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      miss_addr_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
      mem_re_q     <= 1'b0;
      mem_raddr_q  <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      resp_data_q  <= resp_data_d;
      mem_re_q     <= mem_re_d;
      mem_raddr_q  <= mem_raddr_d;
      valid_q      <= valid_d;
    end
  end

  // Line storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_addr  = resp_addr_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_raddr  = mem_raddr_q;

`ifdef DCACHE_STATS_EN
  logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit_inc && !(&hit_count_q))   hit_count_d  = hit_count_q + 1'b1;
    if (miss_inc && !(&miss_count_q)) miss_count_d = miss_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc ^ CNT_WIDTH[0];
`endif

endmodule

// File: tb/tb_dcache_frontend.sv
// tb/tb_dcache_frontend.sv - directed self-checking bench for dcache_frontend
module tb_dcache_frontend;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dcache_frontend_if bus();

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dcache_frontend #(.INDEX_BITS(4), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef DCACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs observed here reflect the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fill(input logic [15:0] addr, input logic [15:0] data);
    bus.mem_ready    = 1'b1;
    bus.mem_raddr_in = addr;
    bus.mem_rdata    = data;
  endtask

  task automatic drive_idle();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_miss(input string tag, input logic [15:0] addr, input logic [15:0] data);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    tick();
    bus.req_valid = 1'b0;
    check({tag, "_mem_re"}, bus.mem_re, 1'b1);
    check({tag, "_mem_raddr"}, bus.mem_raddr, addr);
    check({tag, "_busy"}, bus.req_ready, 1'b0);
    tick();
    check({tag, "_re_pulse"}, bus.mem_re, 1'b0);
    drive_fill(addr, data);
    tick();
    bus.mem_ready = 1'b0;
    check({tag, "_resp_v"}, bus.resp_valid, 1'b1);
    check({tag, "_resp_a"}, bus.resp_addr, addr);
    check({tag, "_resp_d"}, bus.resp_data, data);
    check({tag, "_ready"}, bus.req_ready, 1'b1);
    tick();
    check({tag, "_resp_end"}, bus.resp_valid, 1'b0);
  endtask

  task automatic do_hit(input string tag, input logic [15:0] addr, input logic [15:0] data);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    tick();
    bus.req_valid = 1'b0;
    check({tag, "_resp_v"}, bus.resp_valid, 1'b1);
    check({tag, "_resp_a"}, bus.resp_addr, addr);
    check({tag, "_resp_d"}, bus.resp_data, data);
    check({tag, "_no_re"}, bus.mem_re, 1'b0);
  endtask

  initial begin
    bus.req_addr     = '0;
    bus.mem_raddr_in = '0;
    bus.mem_rdata    = '0;
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_resp_v", bus.resp_valid, 1'b0);
    check("rst_resp_a", bus.resp_addr, 16'h0);
    check("rst_resp_d", bus.resp_data, 16'h0);
    check("rst_mem_re", bus.mem_re, 1'b0);
    check("rst_mem_raddr", bus.mem_raddr, 16'h0);

    // Cold miss with the fill arriving at T+5.
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0123;
    tick();
    bus.req_valid = 1'b0;
    check("cold_re_t1", bus.mem_re, 1'b1);
    check("cold_raddr_t1", bus.mem_raddr, 16'h0123);
    check("cold_ready_t1", bus.req_ready, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check($sformatf("cold_re_t%0d", c), bus.mem_re, 1'b0);
      check($sformatf("cold_ready_t%0d", c), bus.req_ready, 1'b0);
      check($sformatf("cold_resp_t%0d", c), bus.resp_valid, 1'b0);
      check($sformatf("cold_raddr_hold_t%0d", c), bus.mem_raddr, 16'h0123);
    end
    drive_fill(16'h0123, 16'hBEEF);
    tick();
    bus.mem_ready = 1'b0;
    check("cold_resp_v", bus.resp_valid, 1'b1);
    check("cold_resp_a", bus.resp_addr, 16'h0123);
    check("cold_resp_d", bus.resp_data, 16'hBEEF);
    check("cold_ready_t6", bus.req_ready, 1'b1);
    tick();
    check("cold_resp_end", bus.resp_valid, 1'b0);

    // Back-to-back hits.
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0123;
    tick();
    check("hit1_v", bus.resp_valid, 1'b1);
    check("hit1_d", bus.resp_data, 16'hBEEF);
    check("hit1_ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    check("hit2_v", bus.resp_valid, 1'b1);
    check("hit2_a", bus.resp_addr, 16'h0123);
    check("hit2_d", bus.resp_data, 16'hBEEF);
    check("hit2_no_re", bus.mem_re, 1'b0);
    tick();
    check("hit_resp_end", bus.resp_valid, 1'b0);
`ifdef DCACHE_STATS_EN
    check("stats_hits", hit_count, 16'd2);
    check("stats_misses", miss_count, 16'd1);
`endif

    // Conflict on index 3: 0x0133 evicts 0x0123, then 0x0123 evicts 0x0133.
    do_miss("conf_a", 16'h0133, 16'h1111);
    do_hit("conf_a_hit", 16'h0133, 16'h1111);
    do_miss("conf_b", 16'h0123, 16'h2222);
    do_miss("conf_c", 16'h0133, 16'h1112);

    // Mismatched broadcast in WAIT is ignored.
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0200;
    tick();
    bus.req_valid = 1'b0;
    check("mm_re", bus.mem_re, 1'b1);
    tick();
    drive_fill(16'h0456, 16'hAAAA);
    tick();
    bus.mem_ready = 1'b0;
    check("mm_ignored_v", bus.resp_valid, 1'b0);
    check("mm_still_wait", bus.req_ready, 1'b0);
    tick();
    drive_fill(16'h0200, 16'h5555);
    tick();
    bus.mem_ready = 1'b0;
    check("mm_resp_v", bus.resp_valid, 1'b1);
    check("mm_resp_a", bus.resp_addr, 16'h0200);
    check("mm_resp_d", bus.resp_data, 16'h5555);
    tick();
    do_hit("mm_hit", 16'h0200, 16'h5555);

    // Flush, then request: miss.
    do_miss("fl_fill", 16'h0123, 16'h3333);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    do_miss("fl_after", 16'h0123, 16'h3334);

    // Flush together with request in IDLE: flush wins.
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0123;
    tick();
    drive_idle();
    check("fl_same_re", bus.mem_re, 1'b1);
    check("fl_same_no_resp", bus.resp_valid, 1'b0);
    tick();
    drive_fill(16'h0123, 16'h3335);
    tick();
    bus.mem_ready = 1'b0;
    check("fl_same_resp_d", bus.resp_data, 16'h3335);
    tick();

    // Flush during WAIT: the pending fill still lands valid.
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h04FF;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.flush = 1'b1;
    drive_fill(16'h04FF, 16'h7777);
    tick();
    drive_idle();
    check("fl_wait_resp_d", bus.resp_data, 16'h7777);
    tick();
    do_hit("fl_wait_hit", 16'h04FF, 16'h7777);

    // Reset mid-miss, stale return in IDLE ignored.
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0300;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm_ready", bus.req_ready, 1'b1);
    check("rm_resp_v", bus.resp_valid, 1'b0);
    check("rm_resp_a", bus.resp_addr, 16'h0);
    check("rm_resp_d", bus.resp_data, 16'h0);
    check("rm_mem_re", bus.mem_re, 1'b0);
    check("rm_mem_raddr", bus.mem_raddr, 16'h0);
    drive_fill(16'h0300, 16'h9999);
    tick();
    bus.mem_ready = 1'b0;
    check("rm_stale_v", bus.resp_valid, 1'b0);
    check("rm_stale_ready", bus.req_ready, 1'b1);
    do_miss("rm_new", 16'h0300, 16'h9998);
    do_miss("rm_cleared", 16'h04FF, 16'h7778);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
